// File: rtl/fetch_unit_pkg.sv
// Shared CPU types for the fetch stage: address-source select, 6502 addressing
// modes, fetch FSM states and reset-vector locations.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ADDR_PC  = 2'd0,
        ADDR_ABS = 2'd1,
        ADDR_ZP  = 2'd2,
        ADDR_IND = 2'd3
    } mem_addr_choice_t;

    typedef enum logic [3:0] {
        IMPLIED          = 4'd0,
        ACCUMULATOR      = 4'd1,
        IMMEDIATE        = 4'd2,
        ZERO_PAGE        = 4'd3,
        ZERO_PAGE_X      = 4'd4,
        ZERO_PAGE_Y      = 4'd5,
        RELATIVE         = 4'd6,
        ABSOLUTE         = 4'd7,
        ABSOLUTE_X       = 4'd8,
        ABSOLUTE_Y       = 4'd9,
        INDIRECT         = 4'd10,
        INDEXED_INDIRECT = 4'd11,
        INDIRECT_INDEXED = 4'd12
    } addressing_mode_t;

    typedef enum logic [1:0] {
        FS_VEC_LO = 2'd0,
        FS_VEC_HI = 2'd1,
        FS_RUN    = 2'd2
    } fetch_state_t;

    localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;
    localparam logic [1:0]  OPERAND_MAX  = 2'd2;

    // Operand byte counter stops at OPERAND_MAX so extra reads keep landing in op_hi.
    function automatic logic [1:0] operand_cnt_next(input logic [1:0] cnt);
        if (cnt >= OPERAND_MAX) begin
            return OPERAND_MAX;
        end else begin
            return cnt + 2'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_unit_opcode_decoder.sv
// Combinational 6502 opcode -> addressing mode decode; undocumented opcodes
// fall back to IMPLIED.
module opcode_decoder
    import fetch_unit_pkg::*;
(
    input  logic [7:0]       opcode_i,
    output addressing_mode_t mode_o
);

    logic [2:0] aaa_s;
    logic [2:0] bbb_s;
    logic [1:0] cc_s;

    assign aaa_s = opcode_i[7:5];
    assign bbb_s = opcode_i[4:2];
    assign cc_s  = opcode_i[1:0];

    // Decode follows the aaa-bbb-cc grouping of the 6502 opcode map.
    always_comb begin
        mode_o = IMPLIED;
        case (cc_s)
            2'b01: begin
                if (opcode_i == 8'h89) begin
                    mode_o = IMPLIED;
                end else begin
                    case (bbb_s)
                        3'b000:  mode_o = INDEXED_INDIRECT;
                        3'b001:  mode_o = ZERO_PAGE;
                        3'b010:  mode_o = IMMEDIATE;
                        3'b011:  mode_o = ABSOLUTE;
                        3'b100:  mode_o = INDIRECT_INDEXED;
                        3'b101:  mode_o = ZERO_PAGE_X;
                        3'b110:  mode_o = ABSOLUTE_Y;
                        3'b111:  mode_o = ABSOLUTE_X;
                        default: mode_o = IMPLIED;
                    endcase
                end
            end
            2'b10: begin
                case (bbb_s)
                    3'b000:  mode_o = (aaa_s == 3'b101) ? IMMEDIATE : IMPLIED;
                    3'b001:  mode_o = ZERO_PAGE;
                    3'b010:  mode_o = aaa_s[2] ? IMPLIED : ACCUMULATOR;
                    3'b011:  mode_o = ABSOLUTE;
                    3'b101:  mode_o = ((aaa_s == 3'b100) || (aaa_s == 3'b101)) ? ZERO_PAGE_Y : ZERO_PAGE_X;
                    3'b111: begin
                        if (aaa_s == 3'b100) begin
                            mode_o = IMPLIED;
                        end else if (aaa_s == 3'b101) begin
                            mode_o = ABSOLUTE_Y;
                        end else begin
                            mode_o = ABSOLUTE_X;
                        end
                    end
                    default: mode_o = IMPLIED;
                endcase
            end
            2'b00: begin
                case (bbb_s)
                    3'b000: begin
                        if (aaa_s == 3'b001) begin
                            mode_o = ABSOLUTE;
                        end else if (aaa_s >= 3'b101) begin
                            mode_o = IMMEDIATE;
                        end else begin
                            mode_o = IMPLIED;
                        end
                    end
                    3'b001:  mode_o = ((aaa_s == 3'b001) || aaa_s[2]) ? ZERO_PAGE : IMPLIED;
                    3'b011: begin
                        if (aaa_s == 3'b011) begin
                            mode_o = INDIRECT;
                        end else if (aaa_s == 3'b000) begin
                            mode_o = IMPLIED;
                        end else begin
                            mode_o = ABSOLUTE;
                        end
                    end
                    3'b100:  mode_o = RELATIVE;
                    3'b101:  mode_o = ((aaa_s == 3'b100) || (aaa_s == 3'b101)) ? ZERO_PAGE_X : IMPLIED;
                    3'b111:  mode_o = (aaa_s == 3'b101) ? ABSOLUTE_X : IMPLIED;
                    default: mode_o = IMPLIED;
                endcase
            end
            default: mode_o = IMPLIED;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-byte capture stage. Define FETCH_RESET_VECTOR_EN to load the
// PC from the reset vector at FFFC/FFFD; otherwise the PC starts at RESET_PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'hC000
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             block_pc_i,
    input  mem_addr_choice_t addr_choice_i,
    input  logic             pc_load_i,
    input  logic [15:0]      pc_load_value_i,
    input  logic [7:0]       x_i,
    input  logic [7:0]       y_i,
    input  logic [7:0]       mem_rdata_i,
    output logic [15:0]      mem_addr_o,
    output logic [15:0]      pc_o,
    output logic [7:0]       opcode_o,
    output logic [7:0]       op_lo_o,
    output logic [7:0]       op_hi_o,
    output addressing_mode_t addressing_mode_o,
    output logic             ready_o
);

`ifdef FETCH_RESET_VECTOR_EN
    localparam fetch_state_t STATE_AFTER_RESET = FS_VEC_LO;
    localparam logic [15:0]  PC_AFTER_RESET    = 16'h0000;
    localparam logic         READY_AFTER_RESET = 1'b0;
`else
    localparam fetch_state_t STATE_AFTER_RESET = FS_RUN;
    localparam logic [15:0]  PC_AFTER_RESET    = RESET_PC;
    localparam logic         READY_AFTER_RESET = 1'b1;
`endif

    fetch_state_t     state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [7:0]       op_lo_q, op_lo_d;
    logic [7:0]       op_hi_q, op_hi_d;
    logic [1:0]       opcnt_q, opcnt_d;
    logic             ready_q, ready_d;
    logic             pc_inc_s;
    logic [7:0]       index_s;
    logic [15:0]      mem_addr_s;
    addressing_mode_t mode_s;

    opcode_decoder u_decoder (
        .opcode_i (opcode_q),
        .mode_o   (mode_s)
    );

    // Index register applied to absolute addressing, chosen by the latched opcode.
    always_comb begin
        index_s = 8'h00;
        case (mode_s)
            ABSOLUTE_X: index_s = x_i;
            ABSOLUTE_Y: index_s = y_i;
            default:    index_s = 8'h00;
        endcase
    end

    // Memory address mux; kept apart from the next-state logic since read data depends on it.
    always_comb begin
        mem_addr_s = pc_q;
        case (state_q)
            FS_VEC_LO: mem_addr_s = VEC_RESET_LO;
            FS_VEC_HI: mem_addr_s = VEC_RESET_HI;
            FS_RUN: begin
                if (!block_pc_i) begin
                    mem_addr_s = pc_q;
                end else begin
                    case (addr_choice_i)
                        ADDR_PC:  mem_addr_s = pc_q;
                        ADDR_ABS: mem_addr_s = {op_hi_q, op_lo_q} + {8'h00, index_s};
                        ADDR_ZP:  mem_addr_s = {8'h00, op_lo_q + x_i};
                        ADDR_IND: mem_addr_s = {op_hi_q, op_lo_q};
                        default:  mem_addr_s = pc_q;
                    endcase
                end
            end
            default: mem_addr_s = pc_q;
        endcase
    end

    // FSM next state plus PC, opcode and operand capture.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        op_lo_d  = op_lo_q;
        op_hi_d  = op_hi_q;
        opcnt_d  = opcnt_q;
        pc_inc_s = 1'b0;
        case (state_q)
            FS_VEC_LO: begin
                pc_d    = {pc_q[15:8], mem_rdata_i};
                state_d = FS_VEC_HI;
            end
            FS_VEC_HI: begin
                pc_d    = {mem_rdata_i, pc_q[7:0]};
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (!block_pc_i) begin
                    opcode_d = mem_rdata_i;
                    opcnt_d  = 2'd0;
                    pc_inc_s = 1'b1;
                end else if (addr_choice_i == ADDR_PC) begin
                    if (opcnt_q == 2'd0) begin
                        op_lo_d = mem_rdata_i;
                    end else begin
                        op_hi_d = mem_rdata_i;
                    end
                    opcnt_d  = operand_cnt_next(opcnt_q);
                    pc_inc_s = 1'b1;
                end else begin
                    pc_inc_s = 1'b0;
                end
                // A jump target wins over the sequential increment.
                if (pc_load_i) begin
                    pc_d = pc_load_value_i;
                end else if (pc_inc_s) begin
                    pc_d = pc_q + 16'd1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = STATE_AFTER_RESET;
            end
        endcase
        ready_d = (state_d == FS_RUN);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= STATE_AFTER_RESET;
            pc_q     <= PC_AFTER_RESET;
            opcode_q <= 8'h00;
            op_lo_q  <= 8'h00;
            op_hi_q  <= 8'h00;
            opcnt_q  <= 2'd0;
            ready_q  <= READY_AFTER_RESET;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            op_lo_q  <= op_lo_d;
            op_hi_q  <= op_hi_d;
            opcnt_q  <= opcnt_d;
            ready_q  <= ready_d;
        end
    end

    assign mem_addr_o        = mem_addr_s;
    assign pc_o              = pc_q;
    assign opcode_o          = opcode_q;
    assign op_lo_o           = op_lo_q;
    assign op_hi_o           = op_hi_q;
    assign addressing_mode_o = mode_s;
    assign ready_o           = ready_q;

endmodule
